// File: rtl/behaviour_sequencer.sv
// behaviour_sequencer: forward/reverse/turn obstacle-avoidance FSM with tick-timed manoeuvres.
// Define BEHAVIOUR_SEQUENCER_DEBOUNCE_EN to require three consecutive synchronized obstacle samples.
module behaviour_sequencer #(
    parameter int PRESCALE   = 120000,
    parameter int BACK_TICKS = 50,
    parameter int TURN_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       obstacle,
    output logic [1:0] mot_l,
    output logic [1:0] mot_r,
    output logic [1:0] state,
    output logic       avoid_done,
    output logic [7:0] avoid_cnt
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_FWD  = 2'b01;
    localparam logic [1:0] S_BACK = 2'b10;
    localparam logic [1:0] S_TURN = 2'b11;
    localparam logic [23:0] PRE_MAX   = 24'(PRESCALE - 1);
    localparam logic [7:0]  BACK_LAST = 8'(BACK_TICKS - 1);
    localparam logic [7:0]  TURN_LAST = 8'(TURN_TICKS - 1);

    logic [1:0]  st, nxt;
    logic        obs_m, obs_s, accept, tick, entry, finish;
    logic [23:0] pre;
    logic [7:0]  ticks;

    always_ff @(posedge clk) begin
        if (!rst) begin
            obs_m <= 1'b0;
            obs_s <= 1'b0;
        end else begin
            obs_m <= obstacle;
            obs_s <= obs_m;
        end
    end

`ifdef BEHAVIOUR_SEQUENCER_DEBOUNCE_EN
    logic [1:0] hist;
    always_ff @(posedge clk) begin
        if (!rst) hist <= 2'b00;
        else hist <= {hist[0], obs_s};
    end
    assign accept = obs_s & hist[0] & hist[1];
`else
    assign accept = obs_s;
`endif

    assign tick = pre == PRE_MAX;

    always_comb begin
        nxt = !en ? S_IDLE :
              st == S_IDLE ? S_FWD :
              st == S_FWD  ? (accept ? S_BACK : S_FWD) :
              st == S_BACK ? ((tick && ticks == BACK_LAST) ? S_TURN : S_BACK) :
                             ((tick && ticks == TURN_LAST) ? S_FWD : S_TURN);
    end

    // en low clears the timers every cycle, even while already idle
    assign entry  = (nxt != st) || !en;
    assign finish = (st == S_TURN) && (nxt == S_FWD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= S_IDLE;
            pre        <= '0;
            ticks      <= '0;
            avoid_done <= 1'b0;
            avoid_cnt  <= '0;
        end else begin
            st         <= nxt;
            pre        <= (entry || tick) ? 24'd0 : pre + 24'd1;
            ticks      <= entry ? 8'd0 : ticks + {7'd0, tick};
            avoid_done <= finish;
            avoid_cnt  <= avoid_cnt + {7'd0, finish};
        end
    end

    assign state = st;
    assign mot_l = (st == S_FWD || st == S_TURN) ? 2'b01 : (st == S_BACK) ? 2'b10 : 2'b00;
    assign mot_r = (st == S_FWD) ? 2'b01 : st[1] ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_behaviour_sequencer.sv
// tb_behaviour_sequencer: directed vector table plus hand sequences for wrap and reset abort.
module tb_behaviour_sequencer;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_FWD  = 2'b01;
    localparam logic [1:0] S_BACK = 2'b10;
    localparam logic [1:0] S_TURN = 2'b11;
`ifdef BEHAVIOUR_SEQUENCER_DEBOUNCE_EN
    localparam int L = 4;
`else
    localparam int L = 2;
`endif

    typedef struct {
        logic       r, e, o;
        logic [1:0] st;
        logic       dn;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, obstacle = 1'b0;
    logic [1:0] mot_l, mot_r, state;
    logic       avoid_done;
    logic [7:0] avoid_cnt;
    int         tests = 0, fails = 0, nv = 0;
    vec_t       tbl[256];

    behaviour_sequencer #(.PRESCALE(4), .BACK_TICKS(3), .TURN_TICKS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .obstacle(obstacle),
        .mot_l(mot_l), .mot_r(mot_r), .state(state),
        .avoid_done(avoid_done), .avoid_cnt(avoid_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_l(input logic [1:0] s);
        return (s == S_FWD || s == S_TURN) ? 2'b01 : (s == S_BACK) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] exp_r(input logic [1:0] s);
        return (s == S_FWD) ? 2'b01 : (s == S_IDLE) ? 2'b00 : 2'b10;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic seg(input int n, input logic r, input logic e, input logic o,
                       input logic [1:0] s, input logic d, input logic [7:0] c);
        for (int k = 0; k < n; k++) begin
            tbl[nv] = '{r, e, o, s, d, c};
            nv++;
        end
    endtask

    task automatic full(input logic [7:0] c);
        seg(L, 1, 1, 1, S_FWD, 0, c - 8'd1);
        seg(12, 1, 1, 0, S_BACK, 0, c - 8'd1);
        seg(8, 1, 1, 0, S_TURN, 0, c - 8'd1);
        seg(1, 1, 1, 0, S_FWD, 1, c);
        seg(2, 1, 1, 0, S_FWD, 0, c);
    endtask

    initial begin
        logic [7:0] c;
        // reset, release into FORWARD, first 5-cycle obstacle manoeuvre
        seg(2, 0, 1, 0, S_IDLE, 0, 0);
        seg(3, 1, 1, 0, S_FWD, 0, 0);
        seg(L, 1, 1, 1, S_FWD, 0, 0);
        seg(5 - L, 1, 1, 1, S_BACK, 0, 0);
        seg(7 + L, 1, 1, 0, S_BACK, 0, 0);
        seg(8, 1, 1, 0, S_TURN, 0, 0);
        seg(1, 1, 1, 0, S_FWD, 1, 1);
        seg(2, 1, 1, 0, S_FWD, 0, 1);
        c = 8'd1;
`ifdef BEHAVIOUR_SEQUENCER_DEBOUNCE_EN
        seg(2, 1, 1, 1, S_FWD, 0, c);
        seg(6, 1, 1, 0, S_FWD, 0, c);
`else
        seg(2, 1, 1, 1, S_FWD, 0, c);
        seg(12, 1, 1, 0, S_BACK, 0, c);
        seg(8, 1, 1, 0, S_TURN, 0, c);
        c++;
        seg(1, 1, 1, 0, S_FWD, 1, c);
        seg(2, 1, 1, 0, S_FWD, 0, c);
`endif
        // en dropped in the third TURN cycle aborts without completion
        seg(L, 1, 1, 1, S_FWD, 0, c);
        seg(12, 1, 1, 0, S_BACK, 0, c);
        seg(3, 1, 1, 0, S_TURN, 0, c);
        seg(3, 1, 0, 0, S_IDLE, 0, c);
        seg(2, 1, 1, 0, S_FWD, 0, c);
        c++;
        full(c);
        // en low beats a simultaneous obstacle accept in FORWARD
        seg(L, 1, 1, 1, S_FWD, 0, c);
        seg(1, 1, 0, 1, S_IDLE, 0, c);
        seg(3, 1, 0, 0, S_IDLE, 0, c);
        seg(3, 1, 1, 0, S_FWD, 0, c);

        for (int i = 0; i < nv; i++) begin
            rst = tbl[i].r;
            en = tbl[i].e;
            obstacle = tbl[i].o;
            @(posedge clk);
            #1;
            chk("state", i, {14'd0, state}, {14'd0, tbl[i].st});
            chk("mot_l", i, {14'd0, mot_l}, {14'd0, exp_l(tbl[i].st)});
            chk("mot_r", i, {14'd0, mot_r}, {14'd0, exp_r(tbl[i].st)});
            chk("avoid_done", i, {15'd0, avoid_done}, {15'd0, tbl[i].dn});
            chk("avoid_cnt", i, {8'd0, avoid_cnt}, {8'd0, tbl[i].cnt});
        end

        begin
            int pulses = 0, bad = 0, run = 0, cyc = 0;
            logic [7:0] prev;
            logic [1:0] last;
            bit wrapped = 0;
            prev = c;
            last = S_FWD;
            obstacle = 1'b1;
            while (pulses < 256 && cyc < 256 * 21 + 40) begin
                @(posedge clk);
                #1;
                cyc++;
                if (avoid_done) begin
                    pulses++;
                    if (avoid_cnt !== prev + 8'd1 || state !== S_FWD) bad++;
                    if (prev == 8'd255 && avoid_cnt == 8'd0) wrapped = 1;
                    prev = avoid_cnt;
                end
                if (state == S_FWD) run++;
                else begin
                    if (last == S_FWD && pulses > 0 && run != 1) bad++;
                    run = 0;
                end
                last = state;
            end
            chk("loop_pulses", 0, 16'(pulses), 16'd256);
            chk("loop_bad", 0, 16'(bad), 16'd0);
            chk("loop_wrapped", 0, {15'd0, wrapped}, 16'd1);
            chk("loop_cnt", 0, {8'd0, avoid_cnt}, {8'd0, c});
        end

        obstacle = 1'b0;
        @(posedge clk);
        #1;
        chk("back_again", 0, {14'd0, state}, {14'd0, S_BACK});
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_state", 0, {14'd0, state}, {14'd0, S_IDLE});
        chk("rst_mot_l", 0, {14'd0, mot_l}, 16'd0);
        chk("rst_mot_r", 0, {14'd0, mot_r}, 16'd0);
        chk("rst_done", 0, {15'd0, avoid_done}, 16'd0);
        chk("rst_cnt", 0, {8'd0, avoid_cnt}, 16'd0);
        begin
            int odd = 0;
            rst = 1'b1;
            en = 1'b0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (avoid_done !== 1'b0 || avoid_cnt !== 8'd0 || state !== S_IDLE) odd++;
            end
            chk("post_rst_quiet", 0, 16'(odd), 16'd0);
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_state", 0, {14'd0, state}, {14'd0, S_FWD});
        chk("restart_cnt", 0, {8'd0, avoid_cnt}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
